// File: rtl/cfg_bus_arbiter_pkg.sv
// Shared definitions for the configuration bus master/arbiter: state encodings,
// notification codes and the reserved address.
package cfg_bus_arbiter_pkg;

    localparam int unsigned CFG_ADDR_W = 4;
    localparam int unsigned CFG_DATA_W = 14;
    localparam int unsigned TMO_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAIL  = 2'd3
    } state_e;

    localparam logic [3:0] NOTIF_OK   = 4'h1;
    localparam logic [3:0] NOTIF_RSVD = 4'hD;
    localparam logic [3:0] NOTIF_TMO  = 4'hE;
    localparam logic [3:0] RSVD_ADDR  = 4'hF;

endpackage

// File: rtl/cfg_bus_arbiter_if.sv
// Requester and config-bus signals of the arbiter; master is the arbiter's view,
// slave is the view of the requesters and config slaves around it.
interface cfg_bus_arbiter_if #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned N_SLV  = 3,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 14
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ack;
    logic [N_REQ-1:0]        req_err;
    logic                    c_valid;
    logic [ADDR_W-1:0]       c_addr;
    logic [DATA_W-1:0]       c_data;
    logic [N_SLV-1:0]        c_ready;
    logic [3:0]              notif;
    logic                    notif_valid;
    logic                    busy;

    modport master (
        input  req_valid, req_addr, req_data, c_ready,
        output req_ack, req_err, c_valid, c_addr, c_data, notif, notif_valid, busy
    );

    modport slave (
        output req_valid, req_addr, req_data, c_ready,
        input  req_ack, req_err, c_valid, c_addr, c_data, notif, notif_valid, busy
    );
endinterface

// File: rtl/cfg_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts just above the last-grant pointer
// and wraps around, returning a one-hot grant and its index.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    logic             hi_hit;
    logic             lo_hit;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Requests above the pointer take precedence over the wrapped-around ones.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (req_i[j] && (j > 32'(ptr_i)) && !hi_hit) begin
                hi_hit = 1'b1;
                hi_idx = IDX_W'(j);
            end
            if (req_i[j] && (j <= 32'(ptr_i)) && !lo_hit) begin
                lo_hit = 1'b1;
                lo_idx = IDX_W'(j);
            end
        end
        any_o = hi_hit | lo_hit;
        idx_o = hi_hit ? hi_idx : lo_idx;
        gnt_o = any_o ? (N_REQ'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/cfg_bus_arbiter.sv
// Configuration bus master: round-robin arbitration of write requests, one bus
// write at a time with timeout, and completion/error notifications.
module cfg_bus_arbiter
    import cfg_bus_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned N_SLV   = 3,
    parameter int unsigned ADDR_W  = CFG_ADDR_W,
    parameter int unsigned DATA_W  = CFG_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    cfg_bus_arbiter_if.master bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic [DATA_W-1:0] c_data_q, c_data_d;
    logic [3:0]        notif_q, notif_d;
    logic              c_valid_q, c_valid_d;
    logic              notif_valid_q, notif_valid_d;
    logic              busy_q, busy_d;
    logic [N_REQ-1:0]  req_ack_q, req_ack_d;
    logic [N_REQ-1:0]  req_err_q, req_err_d;

    logic [N_REQ-1:0]  rr_gnt;
    logic [IDX_W-1:0]  rr_idx;
    logic              rr_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              bus_rdy;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    assign bus_rdy = &bus.c_ready;

    // Payload of the winning requester.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rr_gnt[i]) begin
                sel_addr = sel_addr | bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        c_addr_d = c_addr_q;
        c_data_d = c_data_q;
        notif_d  = notif_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rr_any && bus_rdy) begin
                    ptr_d    = rr_idx;
                    gnt_d    = rr_idx;
                    c_addr_d = sel_addr;
                    c_data_d = sel_data;
                    cnt_d    = '0;
                    if (sel_addr == ADDR_W'(RSVD_ADDR)) begin
                        state_d = ST_FAIL;
                        notif_d = NOTIF_RSVD;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            // A handshake on the final allowed cycle still counts as a transfer.
            ST_ISSUE: begin
                if (bus_rdy) begin
                    state_d = ST_DONE;
                    notif_d = NOTIF_OK;
                end else if (cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = ST_FAIL;
                    notif_d = NOTIF_TMO;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        c_valid_d     = (state_d == ST_ISSUE);
        busy_d        = (state_d != ST_IDLE);
        notif_valid_d = (state_d == ST_DONE) || (state_d == ST_FAIL);
        req_ack_d     = (state_d == ST_DONE) ? (N_REQ'(1) << gnt_d) : '0;
        req_err_d     = (state_d == ST_FAIL) ? (N_REQ'(1) << gnt_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= IDX_W'(N_REQ - 1);
            gnt_q         <= '0;
            cnt_q         <= '0;
            c_addr_q      <= '0;
            c_data_q      <= '0;
            notif_q       <= '0;
            c_valid_q     <= 1'b0;
            notif_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            req_ack_q     <= '0;
            req_err_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            cnt_q         <= cnt_d;
            c_addr_q      <= c_addr_d;
            c_data_q      <= c_data_d;
            notif_q       <= notif_d;
            c_valid_q     <= c_valid_d;
            notif_valid_q <= notif_valid_d;
            busy_q        <= busy_d;
            req_ack_q     <= req_ack_d;
            req_err_q     <= req_err_d;
        end
    end

    assign bus.c_valid     = c_valid_q;
    assign bus.c_addr      = c_addr_q;
    assign bus.c_data      = c_data_q;
    assign bus.notif       = notif_q;
    assign bus.notif_valid = notif_valid_q;
    assign bus.busy        = busy_q;
    assign bus.req_ack     = req_ack_q;
    assign bus.req_err     = req_err_q;
endmodule
